// File: rtl/neander_mem_sequencer.sv
// neander_mem_sequencer
//   Owns the single program/data RAM and arbitrates it between the host
//   loader port and the Neander CPU. While the CPU is halted the host can
//   burst-write (LOAD) or burst-read (READ) the RAM. RUN hands the RAM to the
//   CPU exclusively. HALT takes it back.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | CPU halted, waiting for a host command
//   LOAD     | accepting host write beats, one RAM write per beat
//   RD_FETCH | reading RAM at ptr into the host_rdata holding register
//   RD_WAIT  | holding host_rdata valid until the host takes it
//   RUN      | CPU owns the RAM; only HALT is accepted from the host
//
// Ports
//   clk, reset               system clock, async active-low reset
//   host_cmd_*               command channel (cmd, burst addr, len 0 = full RAM)
//   host_wdata_*             LOAD data channel
//   host_rdata_*             READ data channel
//   busy, done               burst in progress / one-cycle completion pulse
//   cpu_run                  CPU enable (CPU held in reset while low)
//   cpu_mem_*                CPU memory port
//   ram_*                    RAM port (sync write, async read)
module neander_mem_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter bit RESET_RUN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              host_cmd_valid,
  output logic              host_cmd_ready,
  input  logic [1:0]        host_cmd,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [ADDR_W-1:0] host_len,
  input  logic              host_wdata_valid,
  output logic              host_wdata_ready,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_rdata_valid,
  input  logic              host_rdata_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              done,
  output logic              cpu_run,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [DATA_W-1:0] cpu_mem_wdata,
  input  logic              cpu_mem_write,
  output logic [DATA_W-1:0] cpu_mem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_READ = 2'b01;
  localparam logic [1:0] CMD_RUN  = 2'b10;
  localparam logic [1:0] CMD_HALT = 2'b11;
  // A length field of zero encodes a full-RAM burst, hence the extra count bit.
  localparam logic [CNT_W-1:0] BURST_MAX = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RD_FETCH,
    S_RD_WAIT,
    S_RUN
  } state_t;

  localparam state_t RST_STATE = RESET_RUN ? S_RUN : S_IDLE;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              done_q, done_d;
  logic              run_q, run_d;
  logic [CNT_W-1:0]  burst_len;
  logic              last_beat;

  assign burst_len = (host_len == '0) ? BURST_MAX : {1'b0, host_len};
  assign last_beat = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RST_STATE;
      ptr_q    <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      run_q    <= RESET_RUN;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      run_q    <= run_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    ptr_d            = ptr_q;
    cnt_d            = cnt_q;
    rdata_d          = rdata_q;
    rvalid_d         = rvalid_q;
    done_d           = 1'b0;
    run_d            = run_q;
    host_cmd_ready   = 1'b0;
    host_wdata_ready = 1'b0;
    ram_addr         = ptr_q;
    ram_wdata        = host_wdata;
    ram_we           = 1'b0;

    case (state_q)
      S_IDLE: begin
        host_cmd_ready = 1'b1;
        if (host_cmd_valid) begin
          case (host_cmd)
            CMD_LOAD: begin
              ptr_d   = host_addr;
              cnt_d   = burst_len;
              state_d = S_LOAD;
            end
            CMD_READ: begin
              ptr_d   = host_addr;
              cnt_d   = burst_len;
              state_d = S_RD_FETCH;
            end
            CMD_RUN: begin
              run_d   = 1'b1;
              state_d = S_RUN;
            end
            default: ;  // HALT while already halted is a no-op
          endcase
        end
      end

      S_LOAD: begin
        host_wdata_ready = 1'b1;
        if (host_wdata_valid) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + ADDR_W'(1);
          cnt_d  = cnt_q - CNT_W'(1);
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end

      S_RD_FETCH: begin
        rdata_d  = ram_rdata;
        rvalid_d = 1'b1;
        state_d  = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        if (host_rdata_ready) begin
          rvalid_d = 1'b0;
          cnt_d    = cnt_q - CNT_W'(1);
          if (last_beat) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_RD_FETCH;
          end
        end
      end

      S_RUN: begin
        ram_addr       = cpu_mem_addr;
        ram_wdata      = cpu_mem_wdata;
        ram_we         = cpu_mem_write;
        // Only HALT is acknowledged; anything else waits for the CPU to stop.
        host_cmd_ready = host_cmd_valid && (host_cmd == CMD_HALT);
        if (host_cmd_ready) begin
          run_d   = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy             = (state_q == S_LOAD) || (state_q == S_RD_FETCH) ||
                            (state_q == S_RD_WAIT);
  assign done             = done_q;
  assign cpu_run          = run_q;
  assign host_rdata       = rdata_q;
  assign host_rdata_valid = rvalid_q;
  assign cpu_mem_rdata    = ram_rdata;

endmodule

// File: tb/tb_neander_mem_sequencer.sv
module tb_neander_mem_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       host_cmd_valid, host_cmd_ready;
  logic [1:0] host_cmd;
  logic [7:0] host_addr, host_len;
  logic       host_wdata_valid, host_wdata_ready;
  logic [7:0] host_wdata;
  logic       host_rdata_valid, host_rdata_ready;
  logic [7:0] host_rdata;
  logic       busy, done, cpu_run;
  logic [7:0] cpu_mem_addr, cpu_mem_wdata, cpu_mem_rdata;
  logic       cpu_mem_write;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic       ram_we;

  int tests = 0;
  int fails = 0;

  logic [7:0] ram   [256];
  logic [7:0] model [256];
  logic [7:0] bdata [256];
  logic       ram_clear;
  logic       cpu_force_we;

  always #5 clk = ~clk;

  neander_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .RESET_RUN(1'b0)) dut (
    .clk(clk), .reset(reset),
    .host_cmd_valid(host_cmd_valid), .host_cmd_ready(host_cmd_ready),
    .host_cmd(host_cmd), .host_addr(host_addr), .host_len(host_len),
    .host_wdata_valid(host_wdata_valid), .host_wdata_ready(host_wdata_ready),
    .host_wdata(host_wdata),
    .host_rdata_valid(host_rdata_valid), .host_rdata_ready(host_rdata_ready),
    .host_rdata(host_rdata),
    .busy(busy), .done(done), .cpu_run(cpu_run),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_write(cpu_mem_write), .cpu_mem_rdata(cpu_mem_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  // RAM: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
    end else if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_addr];

  // Minimal Neander core: LDA(20) ADD(30) STA(10) HLT(F0), two-byte instructions
  logic [7:0] pc, ac, ir, opa;
  logic [1:0] phase;
  logic       halted;
  logic [7:0] core_addr;
  logic       core_we;

  always @(posedge clk) begin
    if (!cpu_run) begin
      pc <= 8'h00; ac <= 8'h00; ir <= 8'h00; opa <= 8'h00;
      phase <= 2'd0; halted <= 1'b0;
    end else if (!halted) begin
      case (phase)
        2'd0: begin
          ir <= cpu_mem_rdata;
          pc <= pc + 8'd1;
          if (cpu_mem_rdata == 8'hF0) halted <= 1'b1;
          else if (cpu_mem_rdata == 8'h10 || cpu_mem_rdata == 8'h20 ||
                   cpu_mem_rdata == 8'h30) phase <= 2'd1;
        end
        2'd1: begin
          opa   <= cpu_mem_rdata;
          pc    <= pc + 8'd1;
          phase <= 2'd2;
        end
        default: begin
          if (ir == 8'h20) ac <= cpu_mem_rdata;
          else if (ir == 8'h30) ac <= ac + cpu_mem_rdata;
          phase <= 2'd0;
        end
      endcase
    end
  end

  always_comb begin
    core_addr = pc;
    core_we   = 1'b0;
    if (phase == 2'd2) begin
      core_addr = opa;
      core_we   = (ir == 8'h10);
    end
  end

  assign cpu_mem_addr  = cpu_force_we ? 8'h33 : core_addr;
  assign cpu_mem_wdata = cpu_force_we ? 8'hEE : ac;
  assign cpu_mem_write = core_we | cpu_force_we;

  task automatic issue_cmd(input logic [1:0] c, input logic [7:0] a,
                           input logic [7:0] l, input int max_wait);
    bit ok = 0;
    @(negedge clk);
    host_cmd = c; host_addr = a; host_len = l; host_cmd_valid = 1'b1;
    for (int i = 0; i < max_wait; i++) begin
      #1;
      if (host_cmd_ready === 1'b1) begin ok = 1; break; end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 host_cmd_valid = 1'b0;
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL cmd_accept cmd=%0d: ready never seen, required within %0d cycles", c, max_wait);
    end
  endtask

  task automatic load_burst(input logic [7:0] a, input logic [7:0] l, input int gap_pct);
    int n = (l == 8'd0) ? 256 : int'(l);
    issue_cmd(2'b00, a, l, 4);
    for (int i = 0; i < n; i++) begin
      logic [7:0] ea = a + 8'(i);
      for (int g = 0; g < 2 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
        @(negedge clk);
        host_wdata_valid = 1'b0;
        #1;
        tests++;
        if (ram_we !== 1'b0 || busy !== 1'b1) begin
          fails++;
          $display("FAIL load_gap beat=%0d: ram_we=%b busy=%b, required 0/1", i, ram_we, busy);
        end
      end
      @(negedge clk);
      host_wdata_valid = 1'b1;
      host_wdata = bdata[i];
      #1;
      tests++;
      if (host_wdata_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== ea ||
          ram_wdata !== bdata[i] || done !== 1'b0) begin
        fails++;
        $display("FAIL load_beat %0d: rdy=%b we=%b addr=%h wdata=%h done=%b, required 1/1/%h/%h/0",
                 i, host_wdata_ready, ram_we, ram_addr, ram_wdata, done, ea, bdata[i]);
      end
      @(posedge clk);
      #1 host_wdata_valid = 1'b0;
      model[ea] = bdata[i];
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || host_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_done: done=%b busy=%b cmd_ready=%b, required 1/0/1", done, busy, host_cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL load_done_pulse: done=%b one cycle later, required 0", done);
    end
  endtask

  task automatic read_burst(input logic [7:0] a, input logic [7:0] l,
                            input int min_stall, input int max_stall);
    int n = (l == 8'd0) ? 256 : int'(l);
    issue_cmd(2'b01, a, l, 4);
    for (int i = 0; i < n; i++) begin
      logic [7:0] expv = model[a + 8'(i)];
      bit got = 0;
      int stall;
      for (int w = 0; w < 4; w++) begin
        @(negedge clk);
        if (host_rdata_valid === 1'b1) begin got = 1; break; end
      end
      tests++;
      if (!got) begin
        fails++;
        $display("FAIL rd_valid beat %0d: valid never seen, required within 4 cycles", i);
      end
      tests++;
      if (host_rdata !== expv) begin
        fails++;
        $display("FAIL rd_data beat %0d addr %h: got %h, required %h", i, a + 8'(i), host_rdata, expv);
      end
      stall = int'($urandom_range(min_stall, max_stall));
      for (int s = 0; s < stall; s++) begin
        host_rdata_ready = 1'b0;
        @(negedge clk);
        tests++;
        if (host_rdata_valid !== 1'b1 || host_rdata !== expv || busy !== 1'b1) begin
          fails++;
          $display("FAIL rd_stable beat %0d cycle %0d: valid=%b data=%h busy=%b, required 1/%h/1",
                   i, s, host_rdata_valid, host_rdata, busy, expv);
        end
      end
      host_rdata_ready = 1'b1;
      @(posedge clk);
      #1 host_rdata_ready = 1'b0;
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || host_rdata_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rd_done: done=%b valid=%b busy=%b, required 1/0/0", done, host_rdata_valid, busy);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    tests++;
    if (cpu_run !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || host_rdata_valid !== 1'b0 ||
        host_rdata !== 8'h00 || host_wdata_ready !== 1'b0 || ram_we !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: run=%b busy=%b done=%b rv=%b rd=%h wr=%b we=%b, required all 0",
               cpu_run, busy, done, host_rdata_valid, host_rdata, host_wdata_ready, ram_we);
    end
    tests++;
    if (host_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle_ready: cmd_ready=%b, required 1", host_cmd_ready);
    end
  endtask

  task automatic test_load_basic;
    bdata[0] = 8'hA1; bdata[1] = 8'hB2; bdata[2] = 8'hC3;
    load_burst(8'h10, 8'd3, 0);
    tests++;
    if (ram[8'h10] !== 8'hA1 || ram[8'h11] !== 8'hB2 || ram[8'h12] !== 8'hC3) begin
      fails++;
      $display("FAIL load_basic_ram: %h %h %h, required a1 b2 c3", ram[8'h10], ram[8'h11], ram[8'h12]);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 4; i++) bdata[i] = 8'($urandom);
    load_burst(8'hFE, 8'd4, 30);
    read_burst(8'hFE, 8'd4, 0, 2);
  endtask

  task automatic test_stall;
    read_burst(8'h10, 8'd2, 5, 5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++;
      if (host_rdata_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        fails++;
        $display("FAIL rd_no_extra cycle %0d: valid=%b busy=%b done=%b, required 0/0/0",
                 i, host_rdata_valid, busy, done);
      end
    end
  endtask

  task automatic test_full;
    for (int i = 0; i < 256; i++) bdata[i] = 8'($urandom);
    load_burst(8'h00, 8'd0, 10);
    read_burst(8'h00, 8'd0, 0, 1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 8; k++) begin
      logic [7:0] a = 8'($urandom);
      logic [7:0] l = 8'($urandom_range(1, 24));
      for (int i = 0; i < int'(l); i++) bdata[i] = 8'($urandom);
      load_burst(a, l, 25);
      read_burst(8'($urandom), 8'($urandom_range(1, 12)), 0, 3);
    end
  endtask

  task automatic test_idle_ignore;
    @(negedge clk);
    host_wdata_valid = 1'b1; host_wdata = 8'h77; cpu_force_we = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++;
      if (host_wdata_ready !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL idle_ignore: wready=%b we=%b busy=%b, required 0/0/0", host_wdata_ready, ram_we, busy);
      end
      @(negedge clk);
    end
    host_wdata_valid = 1'b0; cpu_force_we = 1'b0;
    issue_cmd(2'b11, 8'h00, 8'h00, 2);
    @(negedge clk);
    tests++;
    if (cpu_run !== 1'b0 || busy !== 1'b0 || host_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL idle_halt: run=%b busy=%b ready=%b, required 0/0/1", cpu_run, busy, host_cmd_ready);
    end
  endtask

  task automatic test_neander;
    bit seen = 0;
    bdata[0] = 8'h20; bdata[1] = 8'h40; bdata[2] = 8'h30; bdata[3] = 8'h41;
    bdata[4] = 8'h10; bdata[5] = 8'h80; bdata[6] = 8'hF0;
    load_burst(8'h00, 8'd7, 0);
    bdata[0] = 8'h20; bdata[1] = 8'h0A;
    load_burst(8'h40, 8'd2, 0);
    bdata[0] = 8'h55;
    load_burst(8'h80, 8'd1, 0);
    issue_cmd(2'b10, 8'h00, 8'h00, 2);
    @(negedge clk);
    tests++;
    if (cpu_run !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL run_enter: run=%b busy=%b, required 1/0", cpu_run, busy);
    end
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ram[8'h80] === 8'h2A) begin seen = 1; break; end
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL cpu_sta: RAM[80]=%h, required 2a within 60 cycles", ram[8'h80]);
    end
    model[8'h80] = 8'h2A;
    host_cmd = 2'b00; host_addr = 8'h90; host_len = 8'd2; host_cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (host_cmd_ready !== 1'b0 || cpu_run !== 1'b1) begin
        fails++;
        $display("FAIL run_stall cycle %0d: ready=%b run=%b, required 0/1", i, host_cmd_ready, cpu_run);
      end
      @(negedge clk);
    end
    host_cmd_valid = 1'b0;
    issue_cmd(2'b11, 8'h00, 8'h00, 2);
    @(negedge clk);
    tests++;
    if (cpu_run !== 1'b0 || host_cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL halt: run=%b ready=%b, required 0/1", cpu_run, host_cmd_ready);
    end
    bdata[0] = 8'h5A; bdata[1] = 8'hC7;
    load_burst(8'h90, 8'd2, 0);
    read_burst(8'h7E, 8'd4, 0, 1);
  endtask

  task automatic test_reset_mid_load;
    issue_cmd(2'b00, 8'h60, 8'd5, 4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      host_wdata_valid = 1'b1;
      host_wdata = 8'($urandom);
      @(posedge clk);
      #1 host_wdata_valid = 1'b0;
      model[8'h60 + 8'(i)] = host_wdata;
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (busy !== 1'b0 || done !== 1'b0 || host_wdata_ready !== 1'b0 || cpu_run !== 1'b0 ||
        host_rdata_valid !== 1'b0 || host_rdata !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: busy=%b done=%b wr=%b run=%b rv=%b rd=%h, required all 0",
               busy, done, host_wdata_ready, cpu_run, host_rdata_valid, host_rdata);
    end
    @(negedge clk);
    reset = 1'b1;
    host_wdata_valid = 1'b1; host_wdata = 8'hDD;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (done !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL mid_reset_after cycle %0d: done=%b we=%b busy=%b, required 0/0/0", i, done, ram_we, busy);
      end
      @(negedge clk);
    end
    host_wdata_valid = 1'b0;
    read_burst(8'h60, 8'd5, 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; ram_clear = 1'b1; cpu_force_we = 1'b0;
    host_cmd_valid = 1'b0; host_cmd = 2'b00; host_addr = 8'h00; host_len = 8'h00;
    host_wdata_valid = 1'b0; host_wdata = 8'h00; host_rdata_ready = 1'b0;
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk);
    ram_clear = 1'b0;
    reset = 1'b1;
    test_load_basic();
    test_wrap();
    test_stall();
    test_idle_ignore();
    test_full();
    test_random();
    test_neander();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
